// File: rtl/riscv_mc_controller_if.sv
// Control/status bundle between the multi-cycle controller (master) and the datapath (slave).
interface riscv_mc_controller_if;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       sign;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       done;
    logic       illegal;

    modport master (
        input  op, func3, func7, zero, sign,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, done, illegal
    );

    modport slave (
        output op, func3, func7, zero, sign,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, done, illegal
    );
endinterface

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RISC-V main controller FSM (lw/sw/R/I/branch/jal/jalr/lui).
// Define RV_CTRL_ILLEGAL_TRAP_EN to make ILLEGAL a terminal halt state with a sticky flag.
module riscv_mc_controller (
    input  logic                         clk,
    input  logic                         rst,
    riscv_mc_controller_if.master        bus
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALRLINK, LUI, ILLEGAL
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] funct;
    logic       br_legal, br_cond;
    logic       pc_update, branch, ir_write, mem_write, reg_write, done_s, adr_src;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] alu_ctl;

    // Returns {legal, ALUControl} for R-type and I-ALU encodings.
    function automatic logic [3:0] funct_dec(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic [3:0] r;
        logic       f7_ok;
        r     = 4'b0000;
        f7_ok = (op == OP_I) || (f7 == 7'b0000000);
        if (op == OP_R || op == OP_I) begin
            case (f3)
                3'b000: begin
                    if (f7_ok)                                  r = 4'b1000;
                    else if (op == OP_R && f7 == 7'b0100000)    r = 4'b1001;
                end
                3'b111:  if (f7_ok) r = 4'b1010;
                3'b110:  if (f7_ok) r = 4'b1011;
                3'b100:  if (f7_ok) r = 4'b1100;
                3'b010:  if (f7_ok) r = 4'b1101;
                default: r = 4'b0000;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        funct    = funct_dec(bus.op, bus.func3, bus.func7);
        br_legal = 1'b1;
        br_cond  = 1'b0;
        case (bus.func3)
            3'b000:  br_cond = bus.zero;
            3'b001:  br_cond = !bus.zero;
            3'b100:  br_cond = bus.sign;
            3'b101:  br_cond = !bus.sign;
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 3'b001;
            OP_B:    bus.ImmSrc = 3'b010;
            OP_JAL:  bus.ImmSrc = 3'b011;
            OP_LUI:  bus.ImmSrc = 3'b100;
            default: bus.ImmSrc = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_update  = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        done_s     = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu_ctl    = 3'b000;
        case (state_q)
            FETCH: begin
                ir_write = 1'b1; src_b = 2'b10; result_src = 2'b10; pc_update = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                src_a = 2'b01; src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:    state_d = funct[3] ? EXECR : ILLEGAL;
                    OP_I:    state_d = funct[3] ? EXECI : ILLEGAL;
                    OP_B:    state_d = br_legal ? BRANCH : ILLEGAL;
                    OP_JAL:  state_d = JAL;
                    OP_JALR: state_d = JALR;
                    OP_LUI:  state_d = LUI;
                    default: state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                src_a = 2'b10; src_b = 2'b01;
                state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD:  begin adr_src = 1'b1; state_d = MEMWB; end
            MEMWB:    begin result_src = 2'b01; reg_write = 1'b1; done_s = 1'b1; state_d = FETCH; end
            MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; done_s = 1'b1; state_d = FETCH; end
            EXECR:    begin src_a = 2'b10; alu_ctl = funct[2:0]; state_d = ALUWB; end
            EXECI:    begin src_a = 2'b10; src_b = 2'b01; alu_ctl = funct[2:0]; state_d = ALUWB; end
            ALUWB:    begin reg_write = 1'b1; done_s = 1'b1; state_d = FETCH; end
            BRANCH: begin
                src_a = 2'b10; alu_ctl = 3'b001; branch = 1'b1; done_s = 1'b1;
                state_d = FETCH;
            end
            JAL:      begin src_a = 2'b01; src_b = 2'b10; pc_update = 1'b1; state_d = ALUWB; end
            JALR: begin
                src_a = 2'b10; src_b = 2'b01; result_src = 2'b10; pc_update = 1'b1;
                state_d = JALRLINK;
            end
            JALRLINK: begin src_a = 2'b01; src_b = 2'b10; state_d = ALUWB; end
            LUI:      begin result_src = 2'b11; reg_write = 1'b1; done_s = 1'b1; state_d = FETCH; end
            ILLEGAL: begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                state_d = ILLEGAL;
`else
                done_s  = 1'b1;
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    illegal_q <= 1'b0;
        else if (state_d == ILLEGAL) illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    // Strobes are gated by rst so FETCH's Moore outputs stay quiet while held in reset.
    assign bus.PCWrite    = rst & (pc_update | (branch & br_cond));
    assign bus.IRWrite    = rst & ir_write;
    assign bus.MemWrite   = rst & mem_write;
    assign bus.RegWrite   = rst & reg_write;
    assign bus.done       = rst & done_s;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ALUControl = alu_ctl;
endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller: directed instructions plus random ones vs. a per-instruction model.
module tb_riscv_mc_controller;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum int {C_LW, C_SW, C_R, C_I, C_B, C_JAL, C_JALR, C_LUI, C_ILL} cls_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    riscv_mc_controller_if bus ();
    riscv_mc_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction class and ALU operation derived from the ISA subset tables.
    function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, output logic [2:0] alu);
        logic [2:0] a;
        a   = (f3 == 3'b000) ? 3'd0 : (f3 == 3'b111) ? 3'd2 : (f3 == 3'b110) ? 3'd3 :
              (f3 == 3'b100) ? 3'd4 : (f3 == 3'b010) ? 3'd5 : 3'd7;
        alu = a;
        if (op == OP_LW)   return C_LW;
        if (op == OP_SW)   return C_SW;
        if (op == OP_JAL)  return C_JAL;
        if (op == OP_JALR) return C_JALR;
        if (op == OP_LUI)  return C_LUI;
        if (op == OP_I)    return (a == 3'd7) ? C_ILL : C_I;
        if (op == OP_B)    return (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) ? C_B : C_ILL;
        if (op == OP_R) begin
            if (a == 3'd7) return C_ILL;
            if (f7 == 7'd0) return C_R;
            if (f7 == 7'b0100000 && f3 == 3'b000) begin alu = 3'd1; return C_R; end
            return C_ILL;
        end
        return C_ILL;
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == OP_SW)  return 3'b001;
        if (op == OP_B)   return 3'b010;
        if (op == OP_JAL) return 3'b011;
        if (op == OP_LUI) return 3'b100;
        return 3'b000;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".PCWrite"},  bus.PCWrite,  8'd0);
        check({tag, ".IRWrite"},  bus.IRWrite,  8'd0);
        check({tag, ".MemWrite"}, bus.MemWrite, 8'd0);
        check({tag, ".RegWrite"}, bus.RegWrite, 8'd0);
        check({tag, ".done"},     bus.done,     8'd0);
    endtask

    // Entered right after a negedge; leaves rst released one ns after a rising edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_quiet({tag, ".rst_async"});
        check({tag, ".rst_illegal"}, bus.illegal, 8'd0);
        @(posedge clk);
        #1;
        check_quiet({tag, ".rst_held"});
        rst = 1'b1;
    endtask

    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic s,
                             input bit abort_last);
        cls_t       cls;
        logic [2:0] alu;
        int         cpi;
        logic       taken, wb, e_pcw, e_adr;
        logic [1:0] e_rs, e_a, e_b;
        logic [2:0] e_alu;
        string      t;
        bus.op = op; bus.func3 = f3; bus.func7 = f7; bus.zero = z; bus.sign = s;
        cls = classify(op, f3, f7, alu);
        case (cls)
            C_LW, C_JALR:         cpi = 5;
            C_SW, C_R, C_I, C_JAL: cpi = 4;
            default:              cpi = 3;
        endcase
        taken = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) || (f3 == 3'b100 && s) || (f3 == 3'b101 && !s);
        wb = (cls == C_LW || cls == C_R || cls == C_I || cls == C_JAL || cls == C_JALR || cls == C_LUI);
        for (int c = 1; c <= cpi; c++) begin
            e_pcw = (c == 1) || (c == 3 && ((cls == C_B && taken) || cls == C_JAL || cls == C_JALR));
            e_adr = (c == 4) && (cls == C_LW || cls == C_SW);
            e_rs  = 2'd0;
            if (c == 1)                      e_rs = 2'd2;
            if (cls == C_LW && c == 5)       e_rs = 2'd1;
            if (cls == C_JALR && c == 3)     e_rs = 2'd2;
            if (cls == C_LUI && c == 3)      e_rs = 2'd3;
            e_a = 2'd0;
            e_b = 2'd0;
            if (c == 1) e_b = 2'd2;
            if (c == 2) begin e_a = 2'd1; e_b = 2'd1; end
            if (c == 3) begin
                if (cls == C_LW || cls == C_SW || cls == C_R || cls == C_I || cls == C_B || cls == C_JALR) e_a = 2'd2;
                if (cls == C_JAL) begin e_a = 2'd1; e_b = 2'd2; end
                if (cls == C_LW || cls == C_SW || cls == C_I || cls == C_JALR) e_b = 2'd1;
            end
            if (c == 4 && cls == C_JALR) begin e_a = 2'd1; e_b = 2'd2; end
            e_alu = 3'd0;
            if (c == 3 && (cls == C_R || cls == C_I)) e_alu = alu;
            if (c == 3 && cls == C_B)                 e_alu = 3'd1;
            @(negedge clk);
            t = $sformatf("%s.c%0d", name, c);
            check({t, ".IRWrite"},    bus.IRWrite,    8'(c == 1));
            check({t, ".PCWrite"},    bus.PCWrite,    8'(e_pcw));
            check({t, ".RegWrite"},   bus.RegWrite,   8'(c == cpi && wb));
            check({t, ".MemWrite"},   bus.MemWrite,   8'(c == cpi && cls == C_SW));
            check({t, ".done"},       bus.done,       8'(c == cpi));
            check({t, ".AdrSrc"},     bus.AdrSrc,     8'(e_adr));
            check({t, ".ResultSrc"},  bus.ResultSrc,  8'(e_rs));
            check({t, ".ALUSrcA"},    bus.ALUSrcA,    8'(e_a));
            check({t, ".ALUSrcB"},    bus.ALUSrcB,    8'(e_b));
            check({t, ".ALUControl"}, bus.ALUControl, 8'(e_alu));
            check({t, ".ImmSrc"},     bus.ImmSrc,     8'(imm_of(op)));
            check({t, ".illegal"},    bus.illegal,    8'd0);
        end
        if (abort_last) begin
            rst = 1'b0;
            #1;
            check_quiet({name, ".abort"});
            @(posedge clk);
            #1;
            rst = 1'b1;
        end
    endtask

    initial begin
        logic [6:0] op, f7;
        logic [2:0] f3, alu;
        cls_t       cls;
        bus.op = 7'd0; bus.func3 = 3'd0; bus.func7 = 7'd0; bus.zero = 1'b0; bus.sign = 1'b0;
        #1;
        do_reset("reset");

        run_instr("add",      OP_R,    3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
        run_instr("sub",      OP_R,    3'b000, 7'b0100000, 1'b0, 1'b0, 1'b0);
        run_instr("slti",     OP_I,    3'b010, 7'b1010101, 1'b0, 1'b0, 1'b0);
        run_instr("lw",       OP_LW,   3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0);
        run_instr("sw",       OP_SW,   3'b010, 7'b0000000, 1'b0, 1'b0, 1'b0);
        run_instr("beq_t",    OP_B,    3'b000, 7'b0000000, 1'b1, 1'b0, 1'b0);
        run_instr("beq_nt",   OP_B,    3'b000, 7'b0000000, 1'b0, 1'b1, 1'b0);
        run_instr("bge_t",    OP_B,    3'b101, 7'b0000000, 1'b0, 1'b0, 1'b0);
        run_instr("blt_nt",   OP_B,    3'b100, 7'b0000000, 1'b1, 1'b0, 1'b0);
        run_instr("jal",      OP_JAL,  3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
        run_instr("jalr",     OP_JALR, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
        run_instr("lui",      OP_LUI,  3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
        run_instr("sw_abort", OP_SW,   3'b010, 7'b0000000, 1'b0, 1'b0, 1'b1);
        run_instr("and_post", OP_R,    3'b111, 7'b0000000, 1'b0, 1'b0, 1'b0);
`ifndef RV_CTRL_ILLEGAL_TRAP_EN
        run_instr("op_zero",  7'b0000000, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
        run_instr("r_badf7",  OP_R,    3'b111, 7'b0100000, 1'b0, 1'b0, 1'b0);
        run_instr("b_badf3",  OP_B,    3'b010, 7'b0000000, 1'b1, 1'b0, 1'b0);
        run_instr("after_ill", OP_I,   3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 8))
                0: op = OP_LW;   1: op = OP_SW;   2: op = OP_R;   3: op = OP_I;
                4: op = OP_B;    5: op = OP_JAL;  6: op = OP_JALR; 7: op = OP_LUI;
                default: op = ($urandom_range(0, 1) == 0) ? 7'b0010111 : 7'b1111111;
            endcase
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1: f7 = 7'b0000000;
                2:    f7 = 7'b0100000;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            cls = classify(op, f3, f7, alu);
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
            if (cls == C_ILL) continue;
`endif
            run_instr($sformatf("rnd%0d", n), op, f3, f7, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        bus.op = 7'b0000000; bus.func3 = 3'd0; bus.func7 = 7'd0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                check_quiet($sformatf("trap.c%0d", c));
                check($sformatf("trap.c%0d.illegal", c), bus.illegal, 8'd1);
            end
        end
        do_reset("trap_clear");
        run_instr("post_trap", OP_R, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
